// File: rtl/instr_enc_pkg.sv
// Shared types for the RV32 instruction encoder/writer: request classes,
// opcode constants, FSM states and the latched request record.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    LW      = 3'd0,
    SW      = 3'd1,
    RTYPE   = 3'd2,
    BRANCH  = 3'd3,
    IALU    = 3'd4,
    JAL     = 3'd5,
    LUI     = 3'd6,
    ILLEGAL = 3'd7
  } enc_kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  // The core decodes lui on this non-standard opcode.
  localparam logic [6:0] OP_LUI    = 7'b0001101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WR    = 2'd2
  } enc_state_e;

  typedef struct packed {
    enc_kind_e   kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } enc_req_t;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32 word packer with immediate range checking; bad flags
// a request that cannot be encoded faithfully.
module instr_pack
  import instr_enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        bad
);

  logic [31:0] imm;
  assign imm = req.imm;

  always_comb begin
    word = '0;
    bad  = 1'b0;
    case (req.kind)
      LW: begin
        word = {imm[11:0], req.rs1, 3'b010, req.rd, OP_LOAD};
        bad  = !in_range(imm, -2048, 2047);
      end
      SW: begin
        word = {imm[11:5], req.rs2, req.rs1, 3'b010, imm[4:0], OP_STORE};
        bad  = !in_range(imm, -2048, 2047);
      end
      RTYPE: begin
        word = {1'b0, req.funct7b5, 5'b00000, req.rs2, req.rs1, req.funct3, req.rd, OP_RTYPE};
      end
      BRANCH: begin
        word = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11], OP_BRANCH};
        bad  = !in_range(imm, -4096, 4094) || imm[0];
      end
      IALU: begin
        word = {imm[11:0], req.rs1, req.funct3, req.rd, OP_IALU};
        bad  = !in_range(imm, -2048, 2047);
      end
      JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OP_JAL};
        bad  = !in_range(imm, -1048576, 1048574) || imm[0];
      end
      LUI: begin
        // Low 12 bits would be silently dropped, so they must be zero.
        word = {imm[31:12], req.rd, OP_LUI};
        bad  = |imm[11:0];
      end
      default: begin
        bad = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_writer.sv
// Accepts instruction requests, encodes them and writes them to sequential
// imem addresses. Define ENC_CHECKSUM_EN to add the chk running-sum output.
module instr_encoder_writer
  import instr_enc_pkg::*;
#(
  parameter int                DEPTH     = 64,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int               CW        = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_kind,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              err,
  output logic [2:0]        err_kind
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       chk
`endif
);

  // Request handshake: a transfer occurs on a rising edge where req_valid and
  // req_ready are both high; the write side transfers where imem_we and
  // imem_ready are both high. Neither side may retract once presented.

  enc_state_e  state;
  enc_state_e  state_next;
  enc_req_t    req_q;
  logic [31:0] pack_word;
  logic        pack_bad;
  logic        accept;
  logic        commit;

  instr_pack u_pack (
    .req  (req_q),
    .word (pack_word),
    .bad  (pack_bad)
  );

  assign full      = (count == CW'(DEPTH));
  assign req_ready = reset_n && !clear && !full && (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign imem_we   = (state == S_WR);
  assign commit    = imem_we && imem_ready && !clear;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_CHECK;
      S_CHECK: state_next = pack_bad ? S_IDLE : S_WR;
      S_WR:    if (imem_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    // Soft clear overrides everything, including a write completing this edge.
    if (clear) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q      <= '0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      count      <= '0;
      err        <= 1'b0;
      err_kind   <= '0;
    end else if (clear) begin
      imem_addr  <= BASE_ADDR;
      count      <= '0;
      err        <= 1'b0;
      err_kind   <= '0;
    end else begin
      if (accept) begin
        req_q <= '{kind:     enc_kind_e'(req_kind),
                   rd:       req_rd,
                   rs1:      req_rs1,
                   rs2:      req_rs2,
                   funct3:   req_funct3,
                   funct7b5: req_funct7b5,
                   imm:      req_imm};
      end
      if (state == S_CHECK) begin
        if (pack_bad) begin
          err <= 1'b1;
          if (!err) err_kind <= req_q.kind;
        end else begin
          imem_wdata <= pack_word;
        end
      end
      if (commit) begin
        imem_addr <= imem_addr + ADDR_W'(4);
        count     <= count + CW'(1);
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset_n || clear) chk <= '0;
    else if (commit)       chk <= chk + imem_wdata;
  end
`endif

endmodule

// File: tb/tb_instr_encoder_writer.sv
// Randomized scoreboard bench for instr_encoder_writer with a field-level
// reference encoder; directed vectors cover the known encodings and edge cases.
module tb_instr_encoder_writer;
  import instr_enc_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_kind;
  logic [4:0]    req_rd;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [2:0]    req_funct3;
  logic          req_funct7b5;
  logic [31:0]   req_imm;
  logic          imem_we;
  logic          imem_ready;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_wdata;
  logic [CW-1:0] count;
  logic          full;
  logic          err;
  logic [2:0]    err_kind;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   chk;
`endif

  instr_encoder_writer #(
    .DEPTH     (DEPTH),
    .ADDR_W    (32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_kind     (req_kind),
    .req_rd       (req_rd),
    .req_rs1      (req_rs1),
    .req_rs2      (req_rs2),
    .req_funct3   (req_funct3),
    .req_funct7b5 (req_funct7b5),
    .req_imm      (req_imm),
    .imem_we      (imem_we),
    .imem_ready   (imem_ready),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .count        (count),
    .full         (full),
    .err          (err),
    .err_kind     (err_kind)
`ifdef ENC_CHECKSUM_EN
    ,
    .chk          (chk)
`endif
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_addr;
  int          m_count;
  bit          m_err;
  logic [2:0]  m_err_kind;
  logic [31:0] m_chk;
  bit          ready_rand;
  bit          hold_pending;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;

  int imm_tab[16] = '{0, 8, -4, 2047, 2048, -2048, -2049, 4094, 4096, -4096,
                      3, 1048574, 1048576, -1048576, 'h12345000, 'h00ABC000};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: field placement straight from the RV32 formats.
  function automatic void model_enc(input logic [2:0] k, input logic [4:0] rd, rs1, rs2,
                                    input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                                    output logic [31:0] w, output bit ok);
    longint s;
    s  = longint'($signed(imm));
    w  = 32'h0;
    ok = 1'b1;
    case (k)
      3'd0: begin ok = (s >= -2048) && (s <= 2047); w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011}; end
      3'd1: begin ok = (s >= -2048) && (s <= 2047); w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011}; end
      3'd2: begin w = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, 7'b0110011}; end
      3'd3: begin
        ok = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      end
      3'd4: begin ok = (s >= -2048) && (s <= 2047); w = {imm[11:0], rs1, f3, rd, 7'b0010011}; end
      3'd5: begin
        ok = (s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      end
      3'd6: begin ok = (imm[11:0] == 12'h0); w = {imm[31:12], rd, 7'b0001101}; end
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_addr     = BASE;
    m_count    = 0;
    m_err      = 1'b0;
    m_err_kind = 3'd0;
    m_chk      = 32'h0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [2:0] k, input logic [4:0] rd, rs1, rs2,
                          input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                          input bit push);
    logic [31:0] w;
    bit          ok;
    int          t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_funct3 = f3; req_funct7b5 = f7; req_imm = imm;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rd = 5'($urandom); req_rs1 = 5'($urandom); req_rs2 = 5'($urandom);
    req_funct3 = 3'($urandom); req_imm = $urandom; req_kind = 3'($urandom);
    model_enc(k, rd, rs1, rs2, f3, f7, imm, w, ok);
    if (ok) begin
      if (push) begin
        exp_q.push_back({m_addr, w});
        m_addr  += 32'd4;
        m_count += 1;
        m_chk   += w;
      end
    end else begin
      if (!m_err) m_err_kind = k;
      m_err = 1'b1;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_reset();
  endtask

  task automatic wait_we(input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!imem_we && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(name, 64'(imem_we), 64'd1);
  endtask

  task automatic check_state(input string name);
    @(negedge clk);
    check({name, "_count"},    64'(count),      64'(m_count));
    check({name, "_addr"},     64'(imem_addr),  64'(m_addr));
    check({name, "_full"},     64'(full),       64'(m_count == DEPTH));
    check({name, "_err"},      64'(err),        64'(m_err));
    check({name, "_err_kind"}, 64'(err_kind),   64'(m_err_kind));
`ifdef ENC_CHECKSUM_EN
    check({name, "_chk"},      64'(chk),        64'(m_chk));
`endif
  endtask

  // ---------------- write-side ready generator ----------------
  always @(posedge clk) begin
    #1;
    if (ready_rand) imem_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      if (hold_pending) begin
        check("hold_addr",  64'(imem_addr),  64'(hold_addr));
        check("hold_wdata", 64'(imem_wdata), 64'(hold_wdata));
      end
      if (imem_ready && !clear) begin
        hold_pending = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'(imem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("wr_addr",  64'(imem_addr),  64'(e[63:32]));
          check("wr_wdata", 64'(imem_wdata), 64'(e[31:0]));
        end
      end else begin
        hold_pending = 1'b1;
        hold_addr    = imem_addr;
        hold_wdata   = imem_wdata;
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_kind = 3'd0;
    req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0; req_funct3 = 3'd0;
    req_funct7b5 = 1'b0; req_imm = 32'd0; imem_ready = 1'b0;
    ready_rand = 1'b0; hold_pending = 1'b0; hold_addr = '0; hold_wdata = '0;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check("reset_we",        64'(imem_we),    64'd0);
    check("reset_wdata",     64'(imem_wdata), 64'd0);
    check("reset_req_ready", 64'(req_ready),  64'd1);
    check_state("reset");

    ready_rand = 1'b1;

    // Known encodings
    send_req(LW, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1);
    drain();
    check("lw_word", 64'(imem_wdata), 64'h0081_2283);
    check_state("lw");
    send_req(SW, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'd12, 1'b1);
    drain();
    check("sw_word", 64'(imem_wdata), 64'h0061_2623);
    send_req(RTYPE, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1);
    drain();
    check("add_word", 64'(imem_wdata), 64'h0020_81B3);
    check_state("sw_add");
    do_clear();
    send_req(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4, 1'b1);
    drain();
    check("beq_word", 64'(imem_wdata), 64'hFE20_8EE3);
    send_req(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1);
    drain();
    check("jal_word", 64'(imem_wdata), 64'h0080_00EF);
    send_req(LUI, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h1234_5000, 1'b1);
    drain();
    check("lui_word", 64'(imem_wdata), 64'h1234_538D);
    check_state("b_j_u");
    do_clear();

    // Rejects: first kind is kept
    send_req(IALU, 5'd1, 5'd1, 5'd0, 3'd0, 1'b0, 32'd2048, 1'b1);
    send_req(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd3, 1'b1);
    drain();
    check("reject_err_kind", 64'(err_kind), 64'd4);
    check_state("reject");
    do_clear();

    // Stalled write
    ready_rand = 1'b0;
    @(posedge clk); #1 imem_ready = 1'b0;
    send_req(LW, 5'd9, 5'd3, 5'd0, 3'd0, 1'b0, 32'd16, 1'b1);
    wait_we("stall_we_seen");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stall_we", 64'(imem_we), 64'd1);
      check("stall_count", 64'(count), 64'd0);
    end
    @(posedge clk); #1 imem_ready = 1'b1;
    @(negedge clk);
    check("stall_we_last", 64'(imem_we), 64'd1);
    @(posedge clk); #1 imem_ready = 1'b0;
    @(negedge clk);
    check("stall_we_done", 64'(imem_we), 64'd0);
    check("stall_count_one", 64'(count), 64'd1);
    drain();
    check_state("stall");
    do_clear();
    ready_rand = 1'b1;

    // Fill to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      send_req(IALU, 5'($urandom), 5'($urandom), 5'd0, 3'($urandom), 1'b0,
               32'($urandom_range(0, 2047)), 1'b1);
    end
    drain();
    check_state("full");
    @(posedge clk); #1 req_valid = 1'b1; req_kind = 3'd0; req_imm = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_req_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_state("full_hold");
    do_clear();
    check_state("full_cleared");

    // Clear aborts a write even with imem_ready high
    ready_rand = 1'b0;
    @(posedge clk); #1 imem_ready = 1'b0;
    send_req(LW, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 32'd20, 1'b0);
    wait_we("abort_we_seen");
    @(posedge clk); #1 clear = 1'b1; imem_ready = 1'b1;
    @(posedge clk); #1 clear = 1'b0; imem_ready = 1'b0;
    model_reset();
    @(negedge clk);
    check("abort_we", 64'(imem_we), 64'd0);
    check_state("abort");

    // Reset mid-write loses the request
    send_req(SW, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd4, 1'b0);
    wait_we("rst_we_seen");
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_we", 64'(imem_we), 64'd0);
    check_state("midreset");
    ready_rand = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 48; i++) begin
      logic [31:0] imm;
      if (m_count == DEPTH) begin
        drain();
        check_state("rand_full");
        do_clear();
      end
      case ($urandom_range(0, 2))
        0:       imm = 32'(imm_tab[$urandom_range(0, 15)]);
        1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        default: imm = $urandom;
      endcase
      send_req(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
               3'($urandom), 1'($urandom), imm, 1'b1);
      if (i % 6 == 5) begin
        drain();
        check_state("rand");
      end
    end
    drain();
    check_state("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Produces RV32 instruction words for the core's instruction memory, mirroring what the core's main decoder consumes.
- Accepts one instruction request at a time over a valid/ready handshake: instruction class plus fields (rd, rs1, rs2, funct3, funct7b5, imm).
- Range-checks the immediate, packs the 32-bit word and writes it to sequential imem addresses over a stallable write handshake.
- Used as the boot/program loader and as a stimulus source for core-level tests.

Parameters:
- DEPTH, 64: max words written before full; count width is clog2(DEPTH)+1.
- ADDR_W, 32: width of imem_addr.
- BASE_ADDR, 0: byte address of the first word; must be word aligned.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  synchronous active-low reset, sampled on the clk rising edge.
- clear  in  1  synchronous soft clear: address, count, err, checksum.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_kind  in  3  instruction class code (package enum).
- req_rd, req_rs1, req_rs2  in  5 each  register fields.
- req_funct3  in  3  used for R, I-ALU and branch; ignored otherwise.
- req_funct7b5  in  1  funct7 bit 5 for R-type.
- req_imm  in  32  immediate as a signed byte offset or value.
- imem_we  out  1  write strobe.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  byte address.
- imem_wdata  out  32  encoded instruction.
- count  out  clog2(DEPTH)+1  words written.
- full  out  1  count == DEPTH.
- err  out  1  sticky: a rejected request was seen.
- err_kind  out  3  req_kind of the first rejected request.

Behaviour:
- Reset (reset_n low at an edge): state IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, count=0, full=0, err=0, err_kind=0, req_ready=0 in the reset cycle.
- FSM: IDLE -> CHECK -> WR -> IDLE; CHECK -> IDLE on a rejected request.
- IDLE:
  - req_ready = !full && !clear.
  - Handshake (req_valid && req_ready) latches all req_* fields and moves to CHECK.
- CHECK (1 cycle): builds the word from the latched fields.
  - lw: imm[11:0] rs1 010 rd 0000011
  - sw: imm[11:5] rs2 rs1 010 imm[4:0] 0100011
  - R: {0,f7b5,00000} rs2 rs1 f3 rd 0110011
  - beq/branch: imm[12] imm[10:5] rs2 rs1 f3 imm[4:1] imm[11] 1100011
  - I-ALU: imm[11:0] rs1 f3 rd 0010011
  - jal: imm[20] imm[10:1] imm[11] imm[19:12] rd 1101111
  - lui: imm[31:12] rd 0001101 (core lui opcode)
  - Rejected when: I/S imm not in [-2048, 2047]; B imm not in [-4096, 4094] or odd; J imm not in [-2^20, 2^20-2] or odd; U imm[11:0] != 0; kind = 7.
  - On reject: err is set; err_kind is captured only if err was 0; return to IDLE; no write; count unchanged.
  - On success: register the word into imem_wdata and go to WR.
- WR:
  - imem_we=1; imem_addr and imem_wdata held stable until imem_ready is sampled 1.
  - On that edge: imem_we=0, imem_addr += 4, count += 1, full updates, go to IDLE.
- Throughput: minimum 3 cycles per word.
- Full: no further requests accepted until clear. The address never wraps.
- clear has priority over everything except reset:
  - Returns to IDLE; imem_addr=BASE_ADDR; count=0; err=0; err_kind=0.
  - Asserted during WR: the write is aborted and imem_we is 0 on the next cycle, even if imem_ready was high in the same cycle (counted as not written).
- reset_n low mid-operation: same as reset; any in-flight request is lost.

Optional Feature:
- ENC_CHECKSUM_EN defined:
  - Adds output chk[31:0], the mod-2^32 sum of every committed imem_wdata.
  - Updated on the same edge as count; zeroed by reset_n and clear.
- Undefined: no chk port and no adder.

Decomposition:
- Package instr_enc_pkg holds:
  - enum enc_kind_e: LW=0, SW=1, RTYPE=2, BRANCH=3, IALU=4, JAL=5, LUI=6, ILLEGAL=7.
  - 7-bit opcode constants, including OP_LUI=7'b0001101.
  - FSM state enum.
- Sub-module instr_pack: combinational packer plus range checker, with outputs word[31:0] and bad.
- Top level holds the FSM, address/count registers and the handshakes.

Test Plan:
- lw rd=5, rs1=2, imm=8 -> one write, wdata=0x00812283, addr=BASE_ADDR, count=1.
- sw rs2=6, rs1=2, imm=12, then R-type add (rd=3, rs1=1, rs2=2, f3=0, f7b5=0) -> 0x00612623 at +0, 0x002081B3 at +4.
- beq rs1=1, rs2=2, imm=-4 -> 0xFE208EE3; jal rd=1, imm=8 -> 0x008000EF; lui rd=7, imm=0x12345000 -> 0x1234538D.
- I-ALU imm=2048, then jal imm=3 -> no imem_we; err=1; err_kind=4 (first reject kept); count unchanged.
- imem_ready held low 3 cycles during WR -> imem_we, addr and wdata stable for 4 cycles; a single count increment.
- DEPTH=4: fill 4 words -> full=1, req_ready=0; clear pulsed in WR of a 5th attempt after refill -> no commit, addr=BASE_ADDR, count=0; with ENC_CHECKSUM_EN, chk equals the sum of committed words, then 0 after clear.
